// File: rtl/mrc_pkg.sv
// Shared state encoding and constants for multi_run_controller and its round counter.
package mrc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_OFFLOAD = 3'd4,
    ST_DONE    = 3'd5
  } mrc_state_e;

  localparam int unsigned NUM_ROUNDS_DEF = 10;
  localparam int unsigned MASK_W_DEF     = 4;
  localparam int unsigned ROUND_CTR_W    = 4;
  localparam int unsigned RUN_CTR_W      = 8;

  // Wide all-ones pattern; users slice it down to their own mask width.
  localparam logic [31:0] MASK_FULL = 32'hFFFF_FFFF;

endpackage

// File: rtl/multi_run_controller_if.sv
// Signal bundle around multi_run_controller: sequencing requests in, one-hot phase strobes out.
// Requests and column masks are plain levels sampled at every rising edge (no valid/ready
// pairing); each output strobe is a level held high for the whole phase it names.
interface multi_run_controller_if
  import mrc_pkg::*;
#(
  parameter int unsigned MASK_W = MASK_W_DEF
);
  logic              cmplt_sts;
  logic              enter_new_pair;
  logic              start;
  logic              track_available;
  logic [MASK_W-1:0] ark2sb4;
  logic [MASK_W-1:0] mc2ark3;
  logic [MASK_W-1:0] mc2ark4;
  logic              init;
  logic              ok2compute;
  logic              perform_offload;
  logic              ok2load;
  logic              done;

  modport master (
    output cmplt_sts, enter_new_pair, start, track_available, ark2sb4, mc2ark3, mc2ark4,
    input  init, ok2compute, perform_offload, ok2load, done
  );

  modport slave (
    input  cmplt_sts, enter_new_pair, start, track_available, ark2sb4, mc2ark3, mc2ark4,
    output init, ok2compute, perform_offload, ok2load, done
  );
endinterface

// File: rtl/mrc_round_ctr.sv
// Round counter for the COMPUTE phase: clear, count-enable and a flag marking the final round.
module mrc_round_ctr
  import mrc_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam logic [ROUND_CTR_W-1:0] LAST_VAL = ROUND_CTR_W'(NUM_ROUNDS - 1);

  logic [ROUND_CTR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High only on the cycle the count steps from NUM_ROUNDS-1 to NUM_ROUNDS.
  assign last_o = en_i && (cnt_q == LAST_VAL);

endmodule

// File: rtl/multi_run_controller.sv
// Moore sequencer for back-to-back AES-128 runs: INIT -> LOAD -> COMPUTE -> OFFLOAD -> DONE/INIT.
// Define MRC_STAGE4_STALL_EN to let mc2ark4 stall the round counter alongside mc2ark3.
module multi_run_controller
  import mrc_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int unsigned MASK_W     = MASK_W_DEF
) (
  input  logic              clk,
  input  logic              cmplt_sts,
  input  logic              rst,
  input  logic              enter_new_pair,
  input  logic              start,
  input  logic              track_available,
  input  logic [MASK_W-1:0] ark2sb4,
  input  logic [MASK_W-1:0] mc2ark3,
  input  logic [MASK_W-1:0] mc2ark4,
  output logic              init,
  output logic              ok2compute,
  output logic              perform_offload,
  output logic              ok2load,
  output logic              done
);

  localparam logic [MASK_W-1:0] MASK_ALL = MASK_FULL[MASK_W-1:0];

  mrc_state_e           state_q, state_d;
  logic                 pending_q, pending_d;
  logic [RUN_CTR_W-1:0] run_cnt_q, run_cnt_d;
  logic                 stall;
  logic                 round_last;
  logic                 ctr_clr;
  logic                 ctr_en;

`ifdef MRC_STAGE4_STALL_EN
  assign stall = (mc2ark3 != '0) || (mc2ark4 != '0);
`else
  // mc2ark4 is deliberately kept out of the stall path so unknowns on it stay contained.
  assign stall = (mc2ark3 != '0);
  logic unused_mc2ark4;
  assign unused_mc2ark4 = ^mc2ark4;
`endif

  assign ctr_clr = (state_q == ST_INIT);
  assign ctr_en  = (state_q == ST_COMPUTE) && !stall;

  mrc_round_ctr #(
    .NUM_ROUNDS(NUM_ROUNDS)
  ) u_round_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (ctr_clr),
    .en_i  (ctr_en),
    .last_o(round_last)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    run_cnt_d = run_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_INIT;
      end
      ST_INIT: begin
        pending_d = 1'b0;
        state_d   = ST_LOAD;
      end
      ST_LOAD: begin
        if (enter_new_pair) pending_d = 1'b1;
        if (track_available && (ark2sb4 == MASK_ALL)) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (enter_new_pair) pending_d = 1'b1;
        if (round_last) state_d = ST_OFFLOAD;
      end
      ST_OFFLOAD: begin
        if (enter_new_pair) pending_d = 1'b1;
        // A request arriving on the completion cycle still chains straight into a new run.
        if (cmplt_sts) begin
          run_cnt_d = run_cnt_q + 1'b1;
          state_d   = (pending_q || enter_new_pair) ? ST_INIT : ST_DONE;
        end
      end
      ST_DONE: begin
        if (start || enter_new_pair) state_d = ST_INIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so each one is a pure decode of state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      pending_q       <= 1'b0;
      run_cnt_q       <= '0;
      init            <= 1'b0;
      ok2load         <= 1'b0;
      ok2compute      <= 1'b0;
      perform_offload <= 1'b0;
      done            <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      run_cnt_q       <= run_cnt_d;
      init            <= (state_d == ST_INIT);
      ok2load         <= (state_d == ST_LOAD);
      ok2compute      <= (state_d == ST_COMPUTE);
      perform_offload <= (state_d == ST_OFFLOAD);
      done            <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_multi_run_controller.sv
// Bench for multi_run_controller: stimulus schedules are built per run from phase lengths
// (load wait, stall count, offload wait) and the observed strobe trace is checked cycle by cycle.
module tb_multi_run_controller;
  import mrc_pkg::*;

  localparam int NR = 10;
  localparam int MW = 4;
`ifdef MRC_STAGE4_STALL_EN
  localparam bit STG4 = 1'b1;
`else
  localparam bit STG4 = 1'b0;
`endif

  // Strobe vector {init, ok2load, ok2compute, perform_offload, done}
  localparam logic [4:0] E_IDLE = 5'b00000;
  localparam logic [4:0] E_INIT = 5'b10000;
  localparam logic [4:0] E_LOAD = 5'b01000;
  localparam logic [4:0] E_COMP = 5'b00100;
  localparam logic [4:0] E_OFF  = 5'b00010;
  localparam logic [4:0] E_DONE = 5'b00001;

  typedef struct packed {
    logic          rst;
    logic          start;
    logic          enp;
    logic          track;
    logic          cmplt;
    logic [MW-1:0] ark;
    logic [MW-1:0] m3;
    logic [MW-1:0] m4;
  } stim_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_run_controller_if #(.MASK_W(MW)) bus ();

  multi_run_controller #(.NUM_ROUNDS(NR), .MASK_W(MW)) dut (
    .clk            (clk),
    .cmplt_sts      (bus.cmplt_sts),
    .rst            (rst),
    .enter_new_pair (bus.enter_new_pair),
    .start          (bus.start),
    .track_available(bus.track_available),
    .ark2sb4        (bus.ark2sb4),
    .mc2ark3        (bus.mc2ark3),
    .mc2ark4        (bus.mc2ark4),
    .init           (bus.init),
    .ok2compute     (bus.ok2compute),
    .perform_offload(bus.perform_offload),
    .ok2load        (bus.ok2load),
    .done           (bus.done)
  );

  // ---------------- scoreboard state ----------------
  stim_t      stim_q[$];
  logic [4:0] exp_q[$];
  logic [4:0] obs_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         model_busy;   // previous run chained, next run starts directly at INIT
  logic [4:0] model_rest;   // strobes while parked (idle or done)
  int         model_runs;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  function automatic stim_t quiet();
    stim_t s;
    s.rst = 1'b0; s.start = 1'b0; s.enp = 1'b0; s.track = 1'b1; s.cmplt = 1'b0;
    s.ark = '1; s.m3 = '0;
    if (STG4) s.m4 = '0;
    else      s.m4 = 'x;
    return s;
  endfunction

  function automatic stim_t noisy(input stim_t b);
    stim_t s = b;
    s.start = 1'($urandom_range(0, 1));
    s.track = 1'($urandom_range(0, 1));
    s.ark   = MW'($urandom_range(0, 15));
    return s;
  endfunction

  task automatic push(input stim_t s, input logic [4:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    rst                 = s.rst;
    bus.start           = s.start;
    bus.enter_new_pair  = s.enp;
    bus.track_available = s.track;
    bus.cmplt_sts       = s.cmplt;
    bus.ark2sb4         = s.ark;
    bus.mc2ark3         = s.m3;
    bus.mc2ark4         = s.m4;
  endtask

  task automatic play();
    obs_q.delete();
    foreach (stim_q[i]) begin
      drive(stim_q[i]);
      @(negedge clk);
      obs_q.push_back({bus.init, bus.ok2load, bus.ok2compute, bus.perform_offload, bus.done});
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int count_bit(input int b);
    int n = 0;
    foreach (obs_q[i]) if (obs_q[i][b] === 1'b1) n++;
    return n;
  endfunction

  task automatic build_park(input int n, input bit noise);
    stim_t s;
    for (int k = 0; k < n; k++) begin
      s = quiet();
      if (noise) begin
        s = noisy(s);
        s.start = 1'b0;
        s.cmplt = 1'($urandom_range(0, 1));
      end
      push(s, model_rest);
    end
  endtask

  // Reference model: one run is INIT(1) + LOAD(l_wait+1) + COMPUTE(NR + stall cycles) + OFFLOAD(w_off+1).
  task automatic build_run(input int l_wait, input int s3, input int s4, input int s_at,
                           input int w_off, input int enp_idx, input bit noise);
    stim_t s;
    int    base, n_comp, span, idx;
    if (!model_busy) begin
      s = quiet();
      if (model_rest == E_DONE && $urandom_range(0, 1) == 1) s.enp = 1'b1;
      else s.start = 1'b1;
      push(s, model_rest);
    end
    s = quiet();
    if (noise) s.start = 1'($urandom_range(0, 1));
    push(s, E_INIT);
    base = stim_q.size();
    for (int k = 0; k < l_wait; k++) begin
      s = quiet();
      if (noise) begin
        s = noisy(s);
        s.cmplt = 1'($urandom_range(0, 1));
        if (s.ark == '1) s.track = 1'b0;
      end else begin
        s.ark = 4'h7;
      end
      push(s, E_LOAD);
    end
    push(quiet(), E_LOAD);
    n_comp = NR + s3 + (STG4 ? s4 : 0);
    for (int k = 0; k < n_comp; k++) begin
      s = quiet();
      if (noise) begin
        s = noisy(s);
        s.cmplt = 1'($urandom_range(0, 1));
        if (!STG4) s.m4 = MW'($urandom_range(0, 15));
      end
      if (k >= s_at && k < s_at + s3)
        s.m3 = noise ? MW'($urandom_range(1, 15)) : MW'(1);
      else if (k >= s_at + s3 && k < s_at + s3 + s4)
        s.m4 = noise ? MW'($urandom_range(1, 15)) : '1;
      push(s, E_COMP);
    end
    for (int k = 0; k <= w_off; k++) begin
      s = quiet();
      if (noise) begin
        s = noisy(s);
        s.m3 = MW'($urandom_range(0, 15));
      end
      s.cmplt = (k == w_off);
      push(s, E_OFF);
    end
    if (enp_idx >= 0) begin
      span = stim_q.size() - base;
      idx  = base + (enp_idx % span);
      s = stim_q[idx];
      s.enp = 1'b1;
      stim_q[idx] = s;
    end
    model_runs++;
    model_busy = (enp_idx >= 0);
    if (!model_busy) model_rest = E_DONE;
  endtask

  task automatic clear_sb();
    stim_q.delete();
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    stim_t s;
    model_busy = 1'b0; model_rest = E_IDLE; model_runs = 0;
    s = quiet(); s.rst = 1'b1; s.start = 1'b1; s.enp = 1'b1;
    push(s, E_IDLE);
    push(s, E_IDLE);
    s = quiet(); s.enp = 1'b1;
    push(s, E_IDLE);
    build_park(3, 1);
    play();
    foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL reset_trace cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (dut.run_cnt_q !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_run_cnt: got %0d expected 0", dut.run_cnt_q);
    end
    clear_sb();
  endtask

  task automatic test_basic_run();
    build_park(2, 0);
    build_run(0, 0, 0, 0, 0, -1, 0);
    build_park(4, 0);
    play();
    foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL basic_trace cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp += 4;
    if (count_bit(4) !== 1) begin n_bad++; $display("FAIL basic_init_cycles: got %0d expected 1", count_bit(4)); end
    if (count_bit(3) !== 1) begin n_bad++; $display("FAIL basic_load_cycles: got %0d expected 1", count_bit(3)); end
    if (count_bit(2) !== NR) begin n_bad++; $display("FAIL basic_compute_cycles: got %0d expected %0d", count_bit(2), NR); end
    if (dut.run_cnt_q !== 8'(model_runs)) begin
      n_bad++;
      $display("FAIL basic_run_cnt: got %0d expected %0d", dut.run_cnt_q, model_runs);
    end
    clear_sb();
  endtask

  task automatic test_load_wait();
    build_run(3, 0, 0, 0, 1, -1, 0);
    play();
    foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL load_wait_trace cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (count_bit(3) !== 4) begin n_bad++; $display("FAIL load_wait_cycles: got %0d expected 4", count_bit(3)); end
    clear_sb();
  endtask

  task automatic test_stall();
    build_run(0, 2, 0, 4, 0, -1, 0);
    play();
    foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL stall_trace cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (count_bit(2) !== NR + 2) begin n_bad++; $display("FAIL stall_compute_cycles: got %0d expected %0d", count_bit(2), NR + 2); end
    clear_sb();
  endtask

  task automatic test_pending();
    build_run(0, 0, 0, 0, 2, 4, 0);
    build_run(0, 0, 0, 0, 0, -1, 0);
    build_park(3, 0);
    play();
    foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL pending_trace cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp += 2;
    if (count_bit(4) !== 2) begin n_bad++; $display("FAIL pending_init_pulses: got %0d expected 2", count_bit(4)); end
    if (obs_q[obs_q.size()-1] !== E_DONE) begin
      n_bad++;
      $display("FAIL pending_done_held: got %b expected %b", obs_q[obs_q.size()-1], E_DONE);
    end
    clear_sb();
  endtask

  task automatic test_reset_mid_compute();
    stim_t s;
    s = quiet(); s.start = 1'b1;
    push(s, model_rest);
    push(quiet(), E_INIT);
    push(quiet(), E_LOAD);
    for (int k = 0; k < 4; k++) push(quiet(), E_COMP);
    s = quiet(); s.rst = 1'b1; s.start = 1'b1; s.enp = 1'b1;
    push(s, E_COMP);
    model_busy = 1'b0; model_rest = E_IDLE; model_runs = 0;
    build_park(3, 0);
    build_run(1, 1, 0, 2, 1, -1, 0);
    build_park(2, 0);
    play();
    foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL rst_mid_trace cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (dut.run_cnt_q !== 8'(model_runs)) begin
      n_bad++;
      $display("FAIL rst_mid_run_cnt: got %0d expected %0d", dut.run_cnt_q, model_runs);
    end
    clear_sb();
  endtask

  task automatic test_stage4();
    build_run(0, 0, 3, 2, 0, -1, 0);
    play();
    foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL stage4_trace cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (count_bit(2) !== (STG4 ? NR + 3 : NR)) begin
      n_bad++;
      $display("FAIL stage4_compute_cycles: got %0d expected %0d", count_bit(2), STG4 ? NR + 3 : NR);
    end
    clear_sb();
  endtask

  task automatic test_random();
    bit pend;
    for (int r = 0; r < 40; r++) begin
      pend = (r != 39) && ($urandom_range(0, 1) == 1);
      build_run($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, NR - 1), $urandom_range(0, 4),
                pend ? int'($urandom_range(0, 40)) : -1, 1);
      if (!pend) build_park($urandom_range(0, 3), 1);
    end
    play();
    foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL random_trace cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (dut.run_cnt_q !== 8'(model_runs)) begin
      n_bad++;
      $display("FAIL random_run_cnt: got %0d expected %0d", dut.run_cnt_q, model_runs);
    end
    clear_sb();
  endtask

  task automatic test_run_counter_wrap();
    for (int r = 0; r < 260; r++) build_run(0, 0, 0, 0, 0, (r != 259) ? 0 : -1, 0);
    play();
    foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL wrap_trace cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (dut.run_cnt_q !== 8'(model_runs % 256)) begin
      n_bad++;
      $display("FAIL wrap_run_cnt: got %0d expected %0d", dut.run_cnt_q, model_runs % 256);
    end
    clear_sb();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive(quiet());
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic_run();
    test_load_wait();
    test_stall();
    test_pending();
    test_reset_mid_compute();
    test_stage4();
    test_random();
    test_run_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
